active_hwt_seq: RTL
===================

# active_hwt_seq

Parametrised, clocked successor to the team's combinational hardware-trojan benchmark. Each of WIDTH lanes computes the golden function Y = D & ((A & B) | C) into a registered output. A sequential trigger watches the A bus for a three-key sequence, then counts TRIG_COUNT further valid samples, then fires and from then on XORs PAYLOAD_MASK into the output. With HWT_EN = 0 the block is the non-active variant, used for side-channel and area comparison.

## Interface
- WIDTH, 4: number of lanes; width of A, B, C, D, Y.
- KEY0, 4'hA: first trigger pattern on A (WIDTH bits).
- KEY1, 4'h5: second trigger pattern.
- KEY2, 4'hF: third trigger pattern.
- TRIG_COUNT, 3: valid samples counted in ARMED before FIRE (≥1).
- PAYLOAD_MASK, 4'h1: lanes inverted while FIRE.
- HWT_EN, 1: 1 = active trojan; 0 = FSM held in IDLE, Y always golden.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- valid  input  1  qualifies A/B/C/D this cycle.
- A  input  WIDTH  operand / trigger observation bus.
- B  input  WIDTH  operand.
- C  input  WIDTH  operand.
- D  input  WIDTH  operand.
- Y  output  WIDTH  registered result.
- y_valid  output  1  Y updated this cycle.
- triggered  output  1  high while state == FIRE (verification visibility).

## Operation
- golden[i] = D[i] & ((A[i] & B[i]) | C[i]), bitwise per lane.
- On valid: Y <= golden ^ (state==FIRE ? PAYLOAD_MASK : 0). The "state" used is the pre-edge state. Without valid, Y holds.
- y_valid <= valid every cycle.
- FSM states: IDLE, S1, S2, ARMED, FIRE. State changes only on valid cycles; it holds when valid = 0.
- IDLE: A==KEY0 -> S1; otherwise stay.
- S1: A==KEY1 -> S2; A==KEY0 -> S1; otherwise -> IDLE.
- S2: A==KEY2 -> ARMED and cnt <= 0; A==KEY0 -> S1; otherwise -> IDLE.
- ARMED: every valid sample increments cnt regardless of A. When cnt == TRIG_COUNT-1 on a valid sample -> FIRE.
- FIRE: sticky; left only by rst.
- Key checks use priority order, KEY1/KEY2 match first, then KEY0. Equal keys are legal and resolve by that order.
- cnt width is $clog2(TRIG_COUNT+1). It never wraps, because ARMED exits at the terminal value.
- HWT_EN = 0: state is forced to IDLE, triggered = 0, and no key logic is generated.

## Timing
- Reset values (asynchronous, immediate on rst): Y = 0, y_valid = 0, triggered = 0, state = IDLE, cnt = 0.
- Latency: 1 cycle from a valid input sample to Y / y_valid.
- Trigger timing: the KEY2 sample plus TRIG_COUNT valid samples complete the sequence. triggered rises on the edge that accepts the TRIG_COUNT-th ARMED sample.
- The sample that causes the FIRE transition is output uncorrupted. Every later valid sample is corrupted.
- Reset mid-sequence or during FIRE returns the block to IDLE with all outputs 0. rst deassertion is synchronous to clk by the system.
- valid gaps anywhere in the sequence are transparent: neither state nor cnt changes.

## Test plan
All scenarios use the default parameters unless stated.
- **Reset / golden**: rst pulse, then valid with A=F, B=F, C=0, D=F -> during rst Y=0, y_valid=0, triggered=0; one cycle after the sample Y=F, y_valid=1.
- **Golden sweep**: 200 random valid vectors avoiding KEY0 on A -> Y matches the golden function each cycle; triggered stays 0.
- **Full trigger**:
  - Stimulus: valid samples with A=A, 5, F, then 3 arbitrary samples, then A=F, B=F, C=0, D=F.
  - Required: triggered=1 after the 6th sample; the 6th sample's Y is uncorrupted; the final sample gives Y=E.
- **Broken / restarted sequence**: A=A, 5, 3 -> state back to IDLE, no trigger. Then A=A, A, 5, F plus 3 samples -> triggered=1.
- **Valid gaps**: the full-trigger sequence with valid=0 for 2 cycles between each beat -> same trigger point counted in valid samples; Y and state hold during gaps.
- **Reset mid-operation / disabled build**:
  - rst asserted in ARMED and again in FIRE -> triggered=0 and Y=0 immediately; the sequence must restart from KEY0.
  - HWT_EN=0 build fed the full-trigger stimulus -> triggered never asserts; Y is always golden.

Source files
------------

// File: rtl/active_hwt_seq.sv
// Registered golden function Y = D & ((A & B) | C) per lane, with an optional
// sequential trojan that inverts PAYLOAD_MASK lanes after a key sequence on A.
//
// state | meaning
// IDLE  | waiting for KEY0 on A
// S1    | KEY0 seen, waiting for KEY1
// S2    | KEY0,KEY1 seen, waiting for KEY2
// ARMED | key sequence complete, counting TRIG_COUNT valid samples
// FIRE  | payload active until rst
module active_hwt_seq #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] KEY0         = 4'hA,
  parameter logic [WIDTH-1:0] KEY1         = 4'h5,
  parameter logic [WIDTH-1:0] KEY2         = 4'hF,
  parameter int               TRIG_COUNT   = 3,
  parameter logic [WIDTH-1:0] PAYLOAD_MASK = 4'h1,
  parameter bit               HWT_EN       = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid,
  output logic             triggered
);

  localparam int CW = $clog2(TRIG_COUNT + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(TRIG_COUNT - 1);

  typedef enum logic [2:0] {IDLE, S1, S2, ARMED, FIRE} state_t;

  logic             fire;
  logic [WIDTH-1:0] golden;

  assign golden    = D & ((A & B) | C);
  assign triggered = fire;

  // fire reflects the pre-edge state, so the sample that enters FIRE is clean
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= valid;
      if (valid) Y <= golden ^ (fire ? PAYLOAD_MASK : '0);
    end
  end

  generate
    if (HWT_EN) begin : g_trojan
      state_t         state_q, state_d;
      logic [CW-1:0]  cnt_q, cnt_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // KEY1/KEY2 take priority over a KEY0 restart when keys are equal
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (valid) begin
          case (state_q)
            IDLE: if (A == KEY0) state_d = S1;
            S1: begin
              if (A == KEY1)      state_d = S2;
              else if (A == KEY0) state_d = S1;
              else                state_d = IDLE;
            end
            S2: begin
              if (A == KEY2) begin
                state_d = ARMED;
                cnt_d   = '0;
              end else if (A == KEY0) begin
                state_d = S1;
              end else begin
                state_d = IDLE;
              end
            end
            ARMED: begin
              cnt_d = cnt_q + 1'b1;
              if (cnt_q == CNT_TC) state_d = FIRE;
            end
            FIRE:    state_d = FIRE;
            default: state_d = IDLE;
          endcase
        end
      end

      assign fire = (state_q == FIRE);
    end else begin : g_passive
      assign fire = 1'b0;
    end
  endgenerate

endmodule
